shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential shift-and-add multiply-accumulate: product = multiplicand*multiplier + addend.
//  Inverse of the iterative divider: quotient*divisor + remainder rebuilds the dividend.
//  Used for fixed-point scaling in the datapath and as an on-chip round-trip checker for divider results.
//  One multiplier bit per cycle; single request in flight; valid-pulse handshake like the divider.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits
// PORTS
//  clk_in          in   1        system clock
//  rst_in          in   1        synchronous reset, active-high
//  multiplicand_in in   WIDTH    operand A (unsigned)
//  multiplier_in   in   WIDTH    operand B (unsigned), scanned LSB first
//  addend_in       in   WIDTH    value added to A*B (unsigned)
//  data_valid_in   in   1        request strobe; sampled only in IDLE
//  product_out     out  2*WIDTH  A*B + addend
//  data_valid_out  out  1        one-cycle pulse: product_out/error_out valid
//  busy_out        out  1        high whenever state != IDLE
//  error_out       out  1        result does not fit in WIDTH bits
// BEHAVIOUR
//  - Single clock clk_in; rst_in synchronous, active-high.
//  - Reset: state=IDLE; count=WIDTH; product_out, data_valid_out and error_out = 0; busy_out=0.
//  - Reset mid-operation aborts the operation; no data_valid_out pulse.
//  - States: IDLE -> MULTIPLYING -> DONE -> IDLE.
//  - IDLE: on data_valid_in, latch registers:
//    - acc = {WIDTH'0, addend_in}
//    - mcand = {WIDTH'0, multiplicand_in}
//    - mplier = multiplier_in
//    - count = WIDTH
//    Clear data_valid_out and error_out. Go to MULTIPLYING.
//  - MULTIPLYING, each cycle:
//    - if mplier[0], acc += mcand
//    - mcand <<= 1; mplier >>= 1; count -= 1
//    - finish when count==1: register acc into product_out.
//      error_out = |acc_next[2W-1:W]; pulse data_valid_out; go to DONE.
//  - DONE: data_valid_out <= 0; go to IDLE.
//  - Latency: accept at edge N, data_valid_out high after edge N+WIDTH.
//    Next request is accepted at edge N+WIDTH+2 at the earliest.
//  - data_valid_in while busy_out=1 is ignored; no queueing and no error flag.
//  - Width: the maximum result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, so acc never wraps in 2W bits.
//  - multiplicand_in=0 or multiplier_in=0 are legal; the result is addend_in.
//  - product_out and error_out hold their values until the next accepted request.
// CONFIGURATION
//  - Macro SHIFT_ADD_MULT_EARLY_EXIT_EN.
//  - Defined: MULTIPLYING also finishes when mplier_next==0.
//    Latency = max(1, bit index of the MSB of multiplier_in + 1) cycles.
//    Example: multiplier 0 -> 1 cycle, multiplier 5 -> 3 cycles.
//  - Undefined: fixed WIDTH-cycle latency; no data-dependent timing.
// STRUCTURE
//  - Package mult_pkg: typedef enum logic [1:0] {IDLE, MULTIPLYING, DONE} mult_state_t.
//  - Package mult_pkg: localparam DEFAULT_WIDTH=32.
//  - Sub-module shift_add_step (combinational).
//    In: acc, mcand, mplier. Out: acc_next, mcand_next, mplier_next.
//  - The FSM and counter stay in this top module.
// TESTING (WIDTH=32)
//  - A=7, B=6, add=3:
//    -> product_out=45, error_out=0, data_valid_out exactly 32 cycles after accept (macro off).
//  - A=B=add=0xFFFFFFFF:
//    -> product_out=0xFFFFFFFF_00000000, error_out=1, single valid pulse.
//  - Divider round trip, A=142, B=7, add=6 (1000/7):
//    -> product_out=1000, error_out=0.
//  - Assert data_valid_in every cycle through one op (A=3, B=4, add=0):
//    -> exactly one valid pulse, product_out=12.
//    -> busy_out low only in IDLE; next accept at edge N+34.
//  - rst_in for 1 cycle at cycle 10 of an op:
//    -> no valid pulse; outputs 0; following A=2, B=9, add=1 gives 19.
//  - Macro on, B=0 and B=5 (A=10, add=1):
//    -> B=0: product 1, valid after 1 cycle. B=5: product 51, valid after 3 cycles.
//    -> macro off: both take 32 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiply-accumulate unit.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLYING,
    DONE
  } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle for shift_add_multiplier; the master drives requests and the slave returns results.
interface shift_add_multiplier_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0]   multiplicand_in;
  logic [WIDTH-1:0]   multiplier_in;
  logic [WIDTH-1:0]   addend_in;
  logic               data_valid_in;
  logic [2*WIDTH-1:0] product_out;
  logic               data_valid_out;
  logic               busy_out;
  logic               error_out;

  modport master (
    output multiplicand_in, multiplier_in, addend_in, data_valid_in,
    input  product_out, data_valid_out, busy_out, error_out
  );

  modport slave (
    input  multiplicand_in, multiplier_in, addend_in, data_valid_in,
    output product_out, data_valid_out, busy_out, error_out
  );

endinterface

// File: rtl/shift_add_multiplier_step.sv
// One shift-and-add iteration: conditionally add the multiplicand, then advance both operands by one bit.
module shift_add_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential multiply-accumulate (A*B + addend), one multiplier bit per cycle, single request in flight.
// Optional SHIFT_ADD_MULT_EARLY_EXIT_EN finishes as soon as no multiplier bits remain.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  shift_add_multiplier_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  mult_state_t       state;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     count;
  logic [PW-1:0]     product_q;
  logic              valid_q;
  logic              busy_q;
  logic              error_q;

  logic [PW-1:0]     acc_next;
  logic [PW-1:0]     mcand_next;
  logic [WIDTH-1:0]  mplier_next;
  logic              finish_c;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  assign finish_c = (count == CW'(1)) || (mplier_next == '0);
`else
  assign finish_c = (count == CW'(1));
`endif

  // Control FSM and datapath registers; busy tracks state != IDLE one-for-one.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      count     <= CW'(WIDTH);
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_valid_in) begin
            acc     <= {{WIDTH{1'b0}}, bus.addend_in};
            mcand   <= {{WIDTH{1'b0}}, bus.multiplicand_in};
            mplier  <= bus.multiplier_in;
            count   <= CW'(WIDTH);
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= MULTIPLYING;
          end
        end
        MULTIPLYING: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          count  <= count - CW'(1);
          if (finish_c) begin
            product_q <= acc_next;
            error_q   <= |acc_next[PW-1:WIDTH];
            valid_q   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.product_out    = product_q;
  assign bus.data_valid_out = valid_q;
  assign bus.busy_out       = busy_q;
  assign bus.error_out      = error_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: latency-level reference model plus directed literal checks.
module tb_shift_add_multiplier;

  localparam int unsigned W = 32;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int early_lat(input logic [W-1:0] b);
    int n = 1;
    for (int i = 0; i < int'(W); i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic int model_lat(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    return early_lat(b);
`else
    return (b === 'x) ? 0 : int'(W);
`endif
  endfunction

  // Reference model: result from plain arithmetic, timing from a latency countdown.
  logic        m_live  = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic [63:0] m_prod  = '0;
  logic [63:0] m_res   = '0;
  int          m_left  = 0;

  always @(posedge clk_in) begin
    m_live = 1'b1;
    if (rst_in) begin
      m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_prod = '0; m_left = 0;
    end else if (!m_busy) begin
      m_valid = 1'b0;
      if (bus.data_valid_in) begin
        m_busy = 1'b1;
        m_err  = 1'b0;
        m_res  = {32'b0, bus.multiplicand_in} * {32'b0, bus.multiplier_in} + {32'b0, bus.addend_in};
        m_left = model_lat(bus.multiplier_in);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_prod  = m_res;
        m_err   = (m_res[63:32] != 32'b0);
      end
    end else begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  always @(negedge clk_in) begin
    if (m_live) begin
      check("busy", 64'(bus.busy_out), 64'(m_busy));
      check("valid", 64'(bus.data_valid_out), 64'(m_valid));
      check("error", 64'(bus.error_out), 64'(m_err));
      check("product", bus.product_out, m_prod);
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ad,
                       input bit noise, output logic [63:0] prod, output logic err, output int lat);
    int k = 0;
    @(negedge clk_in);
    bus.multiplicand_in = a; bus.multiplier_in = b; bus.addend_in = ad; bus.data_valid_in = 1'b1;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
    while (k < 200) begin
      @(negedge clk_in);
      k++;
      if (bus.data_valid_out) break;
      if (noise) begin
        bus.data_valid_in   = 1'($urandom);
        bus.multiplicand_in = $urandom;
        bus.multiplier_in   = $urandom;
        bus.addend_in       = $urandom;
      end
    end
    bus.data_valid_in = 1'b0;
    check("valid_seen", 64'(bus.data_valid_out), 64'd1);
    prod = bus.product_out;
    err  = bus.error_out;
    lat  = k;
    for (int i = 0; i < 10 && bus.busy_out; i++) @(negedge clk_in);
  endtask

  logic [63:0]  p;
  logic         e;
  int           l;
  logic [W-1:0] ra, rb, rad;

  initial begin
    rst_in = 1'b1;
    bus.multiplicand_in = '0; bus.multiplier_in = '0; bus.addend_in = '0; bus.data_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_product", bus.product_out, 64'd0);
    check("rst_valid", 64'(bus.data_valid_out), 64'd0);
    check("rst_busy", 64'(bus.busy_out), 64'd0);
    check("rst_error", 64'(bus.error_out), 64'd0);
    rst_in = 1'b0;

    do_op(32'd7, 32'd6, 32'd3, 1'b0, p, e, l);
    check("7x6+3", p, 64'd45);
    check("7x6+3_err", 64'(e), 64'd0);
    check("7x6+3_lat", 64'(l), EE ? 64'd3 : 64'd32);

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, e, l);
    check("max", p, 64'hFFFF_FFFF_0000_0000);
    check("max_err", 64'(e), 64'd1);
    check("max_lat", 64'(l), 64'd32);
    @(negedge clk_in);
    check("max_single_pulse", 64'(bus.data_valid_out), 64'd0);

    do_op(32'd142, 32'd7, 32'd6, 1'b0, p, e, l);
    check("roundtrip", p, 64'd1000);
    check("roundtrip_err", 64'(e), 64'd0);

    do_op(32'd10, 32'd0, 32'd1, 1'b0, p, e, l);
    check("b0", p, 64'd1);
    check("b0_lat", 64'(l), EE ? 64'd1 : 64'd32);
    do_op(32'd10, 32'd5, 32'd1, 1'b0, p, e, l);
    check("b5", p, 64'd51);
    check("b5_lat", 64'(l), EE ? 64'd3 : 64'd32);

    // Hold the request strobe high across a whole operation.
    begin
      int a_cyc = -1, b_cyc = -1, pulses = 0;
      logic prev_busy = 1'b0;
      @(negedge clk_in);
      bus.multiplicand_in = 32'd3; bus.multiplier_in = 32'd4; bus.addend_in = 32'd0;
      bus.data_valid_in = 1'b1;
      for (int i = 0; i < 100 && b_cyc < 0; i++) begin
        @(negedge clk_in);
        if (bus.busy_out && !prev_busy) begin
          if (a_cyc < 0) a_cyc = cyc; else b_cyc = cyc;
        end
        if (bus.data_valid_out && a_cyc >= 0 && b_cyc < 0) begin
          pulses++;
          check("hold_product", bus.product_out, 64'd12);
        end
        prev_busy = bus.busy_out;
      end
      bus.data_valid_in = 1'b0;
      check("hold_gap", 64'(b_cyc - a_cyc), EE ? 64'd5 : 64'd34);
      check("hold_pulses", 64'(pulses), 64'd1);
      for (int i = 0; i < 100 && !bus.data_valid_out; i++) @(negedge clk_in);
      check("hold_product2", bus.product_out, 64'd12);
      for (int i = 0; i < 10 && bus.busy_out; i++) @(negedge clk_in);
    end

    // Abort an operation with a one-cycle reset.
    begin
      int pulses = 0;
      @(negedge clk_in);
      bus.multiplicand_in = 32'd5; bus.multiplier_in = 32'hFFFF_0000; bus.addend_in = 32'd0;
      bus.data_valid_in = 1'b1;
      @(negedge clk_in);
      bus.data_valid_in = 1'b0;
      repeat (9) begin
        @(negedge clk_in);
        if (bus.data_valid_out) pulses++;
      end
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("abort_pulses", 64'(pulses), 64'd0);
      check("abort_product", bus.product_out, 64'd0);
      check("abort_valid", 64'(bus.data_valid_out), 64'd0);
      check("abort_busy", 64'(bus.busy_out), 64'd0);
      check("abort_error", 64'(bus.error_out), 64'd0);
      do_op(32'd2, 32'd9, 32'd1, 1'b0, p, e, l);
      check("after_abort", p, 64'd19);
    end

    // Randomized operations with optional strobe noise while busy.
    for (int n = 0; n < 60; n++) begin
      case ($urandom % 8)
        0:       ra = '0;
        1:       ra = '1;
        default: ra = $urandom;
      endcase
      case ($urandom % 8)
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'($urandom % 16);
        default: rb = $urandom;
      endcase
      rad = ($urandom % 6 == 0) ? '1 : W'($urandom);
      do_op(ra, rb, rad, 1'($urandom), p, e, l);
      check("rand_product", p, {32'b0, ra} * {32'b0, rb} + {32'b0, rad});
      check("rand_lat", 64'(l), EE ? 64'(early_lat(rb)) : 64'd32);
      repeat ($urandom % 3) @(negedge clk_in);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
